// File: rtl/button_panel_frontend.sv
// rtl/button_panel_frontend.sv - push-button synchroniser, sampled debouncer and press-pulse generator
// Define BUTTON_ACK_FILTER_EN to suppress presses whose request lamp is already lit.
module button_panel_frontend #(
  parameter int SAMPLE_CLKS    = 1000,
  parameter int STABLE_SAMPLES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] rawHallButton,
  input  logic [9:1]  rawCarButton1,
  input  logic [9:1]  rawCarButton2,
  input  logic [11:0] ackHallButton,
  input  logic [9:1]  ackCarButton1,
  input  logic [9:1]  ackCarButton2,
  output logic [11:0] newRealFloorButton,
  output logic [9:1]  newInternalButton1,
  output logic [9:1]  newInternalButton2,
  output logic [29:0] debouncedLevel,
  output logic        anyPress
);
  localparam int NBITS = 30;
  localparam int CW    = $clog2(SAMPLE_CLKS);
  localparam int HW    = STABLE_SAMPLES - 1;

  logic [NBITS-1:0]    rawAll, sync1, sync2;
  logic [NBITS-1:0]    deb, debNext, pulse, pulseNext, ackMask;
  logic [HW-1:0]       hist [NBITS];
  logic [HW-1:0]       histNext [NBITS];
  logic [STABLE_SAMPLES-1:0] window;
  logic [CW-1:0]       count;
  logic                tick;

  assign rawAll = {rawCarButton2, rawCarButton1, rawHallButton};

`ifdef BUTTON_ACK_FILTER_EN
  assign ackMask = {ackCarButton2, ackCarButton1, ackHallButton};
`else
  logic unusedAck;
  assign unusedAck = ^{ackCarButton2, ackCarButton1, ackHallButton};
  assign ackMask   = '0;
`endif

  assign tick = (count == CW'(SAMPLE_CLKS - 1));

  // Only the newest STABLE_SAMPLES-1 samples are kept; the window adds the current sample.
  always_comb begin
    debNext   = deb;
    pulseNext = '0;
    histNext  = hist;
    window    = '0;
    if (tick) begin
      for (int i = 0; i < NBITS; i++) begin
        window      = {hist[i], sync2[i]};
        histNext[i] = window[HW-1:0];
        if (&window) begin
          if (!deb[i]) begin
            debNext[i]   = 1'b1;
            pulseNext[i] = ~ackMask[i];
          end
        end else if (~|window) begin
          debNext[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1    <= '0;
      sync2    <= '0;
      count    <= '0;
      deb      <= '0;
      pulse    <= '0;
      anyPress <= 1'b0;
      for (int i = 0; i < NBITS; i++) hist[i] <= '0;
    end else begin
      sync1    <= rawAll;
      sync2    <= sync1;
      count    <= tick ? '0 : count + CW'(1);
      deb      <= debNext;
      pulse    <= pulseNext;
      anyPress <= |pulseNext;
      for (int i = 0; i < NBITS; i++) hist[i] <= histNext[i];
    end
  end

  assign newRealFloorButton = pulse[11:0];
  assign newInternalButton1 = pulse[20:12];
  assign newInternalButton2 = pulse[29:21];
  assign debouncedLevel     = deb;

endmodule

// File: tb/tb_button_panel_frontend.sv
// tb/tb_button_panel_frontend.sv - randomized bench with a run-length reference model for button_panel_frontend
module tb_button_panel_frontend;
  localparam int SAMPLE  = 4;
  localparam int STABLE  = 3;
`ifdef BUTTON_ACK_FILTER_EN
  localparam int EXP_ACK_PULSES = 0;
`else
  localparam int EXP_ACK_PULSES = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [29:0] rawVec = '0;
  logic [29:0] ackVec = '0;
  logic [11:0] newRealFloorButton;
  logic [9:1]  newInternalButton1, newInternalButton2;
  logic [29:0] debouncedLevel;
  logic        anyPress;
  logic [29:0] dutPulse;

  int nCompared = 0;
  int nMismatch = 0;
  int pulseEvents = 0;

  always #5 clk = ~clk;

  button_panel_frontend #(.SAMPLE_CLKS(SAMPLE), .STABLE_SAMPLES(STABLE)) dut (
    .clk(clk),
    .reset(reset),
    .rawHallButton(rawVec[11:0]),
    .rawCarButton1(rawVec[20:12]),
    .rawCarButton2(rawVec[29:21]),
    .ackHallButton(ackVec[11:0]),
    .ackCarButton1(ackVec[20:12]),
    .ackCarButton2(ackVec[29:21]),
    .newRealFloorButton(newRealFloorButton),
    .newInternalButton1(newInternalButton1),
    .newInternalButton2(newInternalButton2),
    .debouncedLevel(debouncedLevel),
    .anyPress(anyPress)
  );

  assign dutPulse = {newInternalButton2, newInternalButton1, newRealFloorButton};

  // Reference: a level changes once the last STABLE tick samples agree (run length),
  // samples being the raw value two clocks old; history after reset counts as a run of zeros.
  logic [29:0] mD1, mD2, mDeb, mPulse, mSample;
  logic        mAny;
  int          mEdge;
  int          runLen [30];
  bit          runVal [30];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mD1 = '0; mD2 = '0; mDeb = '0; mPulse = '0; mAny = 1'b0; mEdge = 0;
      for (int i = 0; i < 30; i++) begin runLen[i] = STABLE; runVal[i] = 1'b0; end
    end else begin
      mEdge++;
      mSample = mD2;
      mPulse  = '0;
      if (mEdge % SAMPLE == 0) begin
        for (int i = 0; i < 30; i++) begin
          if (mSample[i] == runVal[i]) runLen[i]++;
          else begin runVal[i] = mSample[i]; runLen[i] = 1; end
          if (runLen[i] >= STABLE) begin
            if (runVal[i] && !mDeb[i]) begin
              mDeb[i] = 1'b1;
`ifdef BUTTON_ACK_FILTER_EN
              mPulse[i] = !ackVec[i];
`else
              mPulse[i] = 1'b1;
`endif
            end else if (!runVal[i]) begin
              mDeb[i] = 1'b0;
            end
          end
        end
      end
      mAny = |mPulse;
      mD2  = mD1;
      mD1  = rawVec;
    end
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatch++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    @(negedge clk);
    checkVal("model pulse", {2'b0, dutPulse}, {2'b0, mPulse});
    checkVal("model deb", {2'b0, debouncedLevel}, {2'b0, mDeb});
    checkVal("model any", {31'b0, anyPress}, {31'b0, mAny});
    pulseEvents += $countones(dutPulse);
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) stepCycle();
  endtask

  task automatic waitPulse(input int limit, output int k, output logic [29:0] vec);
    k = 0;
    vec = '0;
    while (k < limit && vec == '0) begin
      stepCycle();
      k++;
      vec = dutPulse;
    end
  endtask

  task automatic doReset();
    reset = 1'b0;
    #1;
    checkVal("async rst pulse", {2'b0, dutPulse}, 32'h0);
    checkVal("async rst deb", {2'b0, debouncedLevel}, 32'h0);
    checkVal("async rst any", {31'b0, anyPress}, 32'h0);
    runCycles(3);
    reset = 1'b1;
  endtask

  initial begin
    int k;
    logic [29:0] vec;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rawVec = 30'($urandom);
      stepCycle();
      checkVal("reset pulse", {2'b0, dutPulse}, 32'h0);
      checkVal("reset deb", {2'b0, debouncedLevel}, 32'h0);
    end

    // button held through reset: first tick 4 clocks after release, pulse on the third tick
    rawVec = 30'h080;
    reset  = 1'b1;
    waitPulse(40, k, vec);
    checkVal("held-through-reset latency", k, 12);
    checkVal("held-through-reset vec", {2'b0, vec}, 32'h80);
    rawVec = '0;
    runCycles(30);

    rawVec[5] = 1'b1;
    waitPulse(20, k, vec);
    checkVal("press latency in range", {31'b0, (k >= 11 && k <= 15)}, 32'h1);
    checkVal("press vec", {2'b0, vec}, 32'h20);
    checkVal("press any", {31'b0, anyPress}, 32'h1);
    pulseEvents = 0;
    runCycles(30);
    checkVal("held no repulse", pulseEvents, 0);
    checkVal("held deb", {31'b0, debouncedLevel[5]}, 32'h1);

    pulseEvents = 0;
    rawVec[14] = 1'b1;
    runCycles(5);
    rawVec[14] = 1'b0;
    runCycles(30);
    checkVal("glitch pulses", pulseEvents, 0);
    checkVal("glitch deb", {31'b0, debouncedLevel[14]}, 32'h0);

    rawVec = rawVec | 30'h0030_0001;
    waitPulse(20, k, vec);
    checkVal("simultaneous vec", {2'b0, vec}, 32'h0030_0001);
    checkVal("simultaneous any", {31'b0, anyPress}, 32'h1);
    runCycles(30);

    rawVec[5] = 1'b0;
    pulseEvents = 0;
    runCycles(20);
    checkVal("release pulses", pulseEvents, 0);
    checkVal("release deb", {31'b0, debouncedLevel[5]}, 32'h0);
    rawVec[5] = 1'b1;
    waitPulse(20, k, vec);
    checkVal("repress vec", {2'b0, vec}, 32'h20);
    runCycles(10);

    ackVec[2] = 1'b1;
    pulseEvents = 0;
    rawVec[2] = 1'b1;
    runCycles(30);
    checkVal("ack pulses", pulseEvents, EXP_ACK_PULSES);
    checkVal("ack deb", {31'b0, debouncedLevel[2]}, 32'h1);
    rawVec = '0;
    ackVec = '0;
    runCycles(30);

    for (int c = 0; c < 3000; c++) begin
      int b;
      if ($urandom_range(3) == 0) begin
        b = int'($urandom_range(29));
        rawVec[b] = ~rawVec[b];
      end
      if (c % 64 == 0) ackVec = 30'($urandom);
      if ($urandom_range(699) == 0) doReset();
      stepCycle();
    end

    // reset landing on a live pulse, button still held afterwards
    rawVec = '0;
    ackVec = '0;
    runCycles(30);
    rawVec[3] = 1'b1;
    waitPulse(20, k, vec);
    checkVal("pre-reset pulse vec", {2'b0, vec}, 32'h8);
    doReset();
    waitPulse(40, k, vec);
    checkVal("post-reset latency", k, 12);
    checkVal("post-reset vec", {2'b0, vec}, 32'h8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end
endmodule
